// File: rtl/common_pkg.sv
// Shared constants and types for the Ising problem loader front end.
package common_pkg;
  localparam int NUM_SPINS  = 8;
  localparam int IDX_W      = 3;
  localparam int PHASE_W    = 8;
  localparam int J_W        = 32;
  localparam int H_W        = 24;
  localparam int RUN_CYCLES = 1024;
  localparam int H_SKIP     = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOADED,
    RST_PE,
    RUN,
    DONE
  } loader_state_t;

  typedef enum logic {
    BEAT_COUPLING = 1'b0,
    BEAT_PHASE    = 1'b1
  } beat_kind_t;
endpackage

// File: rtl/ham_min_tracker.sv
// Anneal run counter plus strict-minimum Hamiltonian tracker with pipeline-fill skip.
module ham_min_tracker #(
  parameter int H_W        = common_pkg::H_W,
  parameter int RUN_CYCLES = common_pkg::RUN_CYCLES,
  parameter int H_SKIP     = common_pkg::H_SKIP,
  parameter int CNT_W      = $clog2(RUN_CYCLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_run,
  input  logic [H_W-1:0]   i_hamiltonian,
  output logic             o_last,
  output logic [H_W-1:0]   o_best_h,
  output logic [CNT_W-1:0] o_best_cycle
);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SKIP_CNT = CNT_W'(H_SKIP);

  logic [CNT_W-1:0] r_cnt;
  logic [H_W-1:0]   r_best_h;
  logic [CNT_W-1:0] r_best_cycle;
  logic             w_sampling;

  assign o_last       = (r_cnt == LAST_CNT);
  assign w_sampling   = (r_cnt >= SKIP_CNT);
  assign o_best_h     = r_best_h;
  assign o_best_cycle = r_best_cycle;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_cnt        <= '0;
      r_best_h     <= '1;
      r_best_cycle <= '0;
    end else if (i_run) begin
      r_cnt <= o_last ? '0 : r_cnt + CNT_W'(1);
      // strict compare keeps the earliest cycle on ties
      if (w_sampling && (i_hamiltonian < r_best_h)) begin
        r_best_h     <= i_hamiltonian;
        r_best_cycle <= r_cnt;
      end
    end
  end
endmodule

// File: rtl/ising_problem_loader.sv
// Problem loader for the Ising PE array: J-matrix/phase register file, anneal sequencing
// and minimum-Hamiltonian reporting.
module ising_problem_loader #(
  parameter int NUM_SPINS  = common_pkg::NUM_SPINS,
  parameter int IDX_W      = common_pkg::IDX_W,
  parameter int PHASE_W    = common_pkg::PHASE_W,
  parameter int J_W        = common_pkg::J_W,
  parameter int H_W        = common_pkg::H_W,
  parameter int RUN_CYCLES = common_pkg::RUN_CYCLES,
  parameter int H_SKIP     = common_pkg::H_SKIP,
  parameter int CNT_W      = $clog2(RUN_CYCLES)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic                             s_kind,
  input  logic [IDX_W-1:0]                 s_row,
  input  logic [IDX_W-1:0]                 s_col,
  input  logic [J_W-1:0]                   s_data,
  input  logic                             s_last,
  input  logic                             start,
  output logic [NUM_SPINS*NUM_SPINS*J_W-1:0] coupling_factor,
  output logic [NUM_SPINS*PHASE_W-1:0]     coupling_phase,
  output logic                             pe_reset,
  output logic                             pe_ena,
  input  logic [H_W-1:0]                   hamiltonian,
  output logic                             busy,
  output logic                             done,
  output logic [H_W-1:0]                   best_h,
  output logic [CNT_W-1:0]                 best_cycle,
  output logic                             err
);
  import common_pkg::*;

  loader_state_t r_state, w_next;

  logic [J_W-1:0]     r_j     [NUM_SPINS][NUM_SPINS];
  logic [PHASE_W-1:0] r_phase [NUM_SPINS];
  logic               r_err;

  logic w_accept, w_row_ok, w_col_ok, w_is_phase;
  logic w_write_j, w_write_ph, w_bad, w_run_last;

  assign w_accept   = s_valid && (r_state == LOAD);
  assign w_row_ok   = 32'(s_row) < 32'(NUM_SPINS);
  assign w_col_ok   = 32'(s_col) < 32'(NUM_SPINS);
  assign w_is_phase = (beat_kind_t'(s_kind) == BEAT_PHASE);
  assign w_write_j  = w_accept && !w_is_phase && w_row_ok && w_col_ok && (s_row != s_col);
  assign w_write_ph = w_accept && w_is_phase && w_row_ok;
  assign w_bad      = w_accept && !w_write_j && !w_write_ph;
  assign err        = r_err;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    s_ready  = 1'b0;
    pe_reset = 1'b1;
    pe_ena   = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (r_state)
      IDLE:   begin
        busy   = 1'b0;
        w_next = LOAD;
      end
      LOAD:   begin
        s_ready = 1'b1;
        if (w_accept && s_last) w_next = LOADED;
      end
      LOADED: if (start) w_next = RST_PE;
      RST_PE: w_next = RUN;
      RUN:    begin
        pe_reset = 1'b0;
        pe_ena   = 1'b1;
        if (w_run_last) w_next = DONE;
      end
      DONE:   begin
        pe_reset = 1'b0;
        busy     = 1'b0;
        done     = 1'b1;
        if (start)        w_next = RST_PE;
        else if (s_valid) w_next = LOAD;
      end
      default: w_next = IDLE;
    endcase
  end

  // both halves of the symmetric pair are written on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_j     <= '{default: '0};
      r_phase <= '{default: '0};
      r_err   <= 1'b0;
    end else begin
      if (w_write_j) begin
        r_j[s_row][s_col] <= s_data;
        r_j[s_col][s_row] <= s_data;
      end
      if (w_write_ph) r_phase[s_row] <= s_data[PHASE_W-1:0];
      if (r_state == DONE && w_next == LOAD) r_err <= 1'b0;
      else if (w_bad)                        r_err <= 1'b1;
    end
  end

  for (genvar gr = 0; gr < NUM_SPINS; gr++) begin : g_row
    assign coupling_phase[gr*PHASE_W +: PHASE_W] = r_phase[gr];
    for (genvar gc = 0; gc < NUM_SPINS; gc++) begin : g_col
      assign coupling_factor[(gr*NUM_SPINS+gc)*J_W +: J_W] = r_j[gr][gc];
    end
  end

  ham_min_tracker #(
    .H_W        (H_W),
    .RUN_CYCLES (RUN_CYCLES),
    .H_SKIP     (H_SKIP),
    .CNT_W      (CNT_W)
  ) u_tracker (
    .clk           (clk),
    .reset         (reset),
    .i_clear       (r_state == RST_PE),
    .i_run         (r_state == RUN),
    .i_hamiltonian (hamiltonian),
    .o_last        (w_run_last),
    .o_best_h      (best_h),
    .o_best_cycle  (best_cycle)
  );
endmodule

// File: tb/tb_ising_problem_loader.sv
// Scoreboard bench: random beats and Hamiltonian streams against a behavioural model.
module tb_ising_problem_loader;
  // 6 spins with 3-bit indices so out-of-range rows/columns are reachable
  localparam int N  = 6;
  localparam int IW = 3;
  localparam int PW = 8;
  localparam int JW = 32;
  localparam int HW = 24;
  localparam int RC = 1024;
  localparam int HS = 2;
  localparam int CW = 10;

  logic clk = 1'b0;
  logic reset, s_valid, s_ready, s_kind, s_last, start;
  logic [IW-1:0] s_row, s_col;
  logic [JW-1:0] s_data;
  logic [N*N*JW-1:0] coupling_factor;
  logic [N*PW-1:0] coupling_phase;
  logic pe_reset, pe_ena, busy, done, err;
  logic [HW-1:0] hamiltonian, best_h;
  logic [CW-1:0] best_cycle;

  always #5 clk = ~clk;

  ising_problem_loader #(
    .NUM_SPINS(N), .IDX_W(IW), .PHASE_W(PW), .J_W(JW), .H_W(HW),
    .RUN_CYCLES(RC), .H_SKIP(HS), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_kind(s_kind),
    .s_row(s_row), .s_col(s_col), .s_data(s_data), .s_last(s_last), .start(start),
    .coupling_factor(coupling_factor), .coupling_phase(coupling_phase),
    .pe_reset(pe_reset), .pe_ena(pe_ena), .hamiltonian(hamiltonian), .busy(busy),
    .done(done), .best_h(best_h), .best_cycle(best_cycle), .err(err)
  );

  typedef struct {
    logic [HW-1:0] h;
    logic [CW-1:0] c;
    logic [JW-1:0] j [N][N];
    logic [PW-1:0] ph [N];
  } exp_t;

  logic [JW-1:0] m_j [N][N];
  logic [PW-1:0] m_ph [N];
  logic          m_err;
  logic [HW-1:0] hseq [RC];
  exp_t          sb[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < N; r++) begin
      m_ph[r] = '0;
      for (int c = 0; c < N; c++) m_j[r][c] = '0;
    end
    m_err = 1'b0;
  endtask

  task automatic model_beat(input int kind, input int row, input int col, input logic [JW-1:0] data);
    if (kind == 0) begin
      if (row >= N || col >= N || row == col) m_err = 1'b1;
      else begin
        m_j[row][col] = data;
        m_j[col][row] = data;
      end
    end else begin
      if (row >= N) m_err = 1'b1;
      else m_ph[row] = data[PW-1:0];
    end
  endtask

  task automatic check_regs(input string tag);
    for (int r = 0; r < N; r++) begin
      chk($sformatf("%s phase[%0d]", tag, r), coupling_phase[r*PW +: PW], m_ph[r]);
      for (int c = 0; c < N; c++)
        chk($sformatf("%s J[%0d][%0d]", tag, r, c), coupling_factor[(r*N+c)*JW +: JW], m_j[r][c]);
    end
    chk({tag, " err"}, err, m_err);
  endtask

  task automatic send_beat(input int kind, input int row, input int col,
                           input logic [JW-1:0] data, input logic last);
    int w;
    @(negedge clk);
    s_valid = 1'b1;
    s_kind  = kind[0];
    s_row   = row[IW-1:0];
    s_col   = col[IW-1:0];
    s_data  = data;
    s_last  = last;
    w = 0;
    while (!s_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!s_ready) chk("beat accept timeout s_ready", s_ready, 1);
    else begin
      @(posedge clk);
      model_beat(kind, row, col, data);
      #1;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    start   = 1'b0;
  endtask

  task automatic random_load(input int nbeats);
    for (int b = 0; b < nbeats; b++)
      send_beat($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom, (b == nbeats - 1));
    idle();
  endtask

  task automatic fill_random_h(input int lo, input int hi);
    for (int k = 0; k < RC; k++) hseq[k] = HW'($urandom_range(lo, hi));
    hseq[0] = '0;
    hseq[1] = '0;
  endtask

  task automatic push_expected();
    exp_t e;
    e.h = '1;
    e.c = '0;
    for (int k = HS; k < RC; k++)
      if (hseq[k] < e.h) begin
        e.h = hseq[k];
        e.c = CW'(k);
      end
    e.j  = m_j;
    e.ph = m_ph;
    sb.push_back(e);
  endtask

  task automatic run_anneal();
    int w, ena_cnt;
    push_expected();
    @(negedge clk);
    s_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rst_pe pe_reset", pe_reset, 1);
    chk("rst_pe pe_ena", pe_ena, 0);
    chk("rst_pe busy", busy, 1);
    w = 0;
    ena_cnt = 0;
    while (!done && w < RC + 20) begin
      @(negedge clk);
      w++;
      if (pe_ena) ena_cnt++;
      if (w == 1) begin
        chk("run pe_reset", pe_reset, 0);
        chk("run pe_ena", pe_ena, 1);
      end
    end
    chk("done timeout", done, 1);
    chk("pe_ena cycles", ena_cnt, RC);
    chk("done pe_reset", pe_reset, 0);
    chk("done busy", busy, 0);
  endtask

  // Hamiltonian source: one sample per enabled array cycle, junk outside the window
  initial begin
    int k;
    k = 0;
    hamiltonian = '0;
    forever begin
      @(negedge clk);
      if (pe_ena) begin
        hamiltonian = hseq[k % RC];
        k++;
      end else begin
        k = 0;
        hamiltonian = HW'($urandom_range(0, 3));
      end
    end
  end

  // Monitor: each rising done pops one expectation; result must hold while done stays high
  initial begin
    logic pd;
    exp_t cur;
    pd = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !pd) begin
        if (sb.size() == 0) chk("scoreboard entry present", sb.size(), 1);
        else begin
          cur = sb.pop_front();
          chk("best_h", best_h, cur.h);
          chk("best_cycle", best_cycle, cur.c);
          for (int r = 0; r < N; r++) begin
            chk($sformatf("done phase[%0d]", r), coupling_phase[r*PW +: PW], cur.ph[r]);
            for (int c = 0; c < N; c++)
              chk($sformatf("done J[%0d][%0d]", r, c),
                  coupling_factor[(r*N+c)*JW +: JW], cur.j[r][c]);
          end
        end
      end else if (done && pd) begin
        chk("hold best_h", best_h, cur.h);
        chk("hold best_cycle", best_cycle, cur.c);
      end
      pd = done;
    end
  end

  initial begin
    int w, ena_cnt;
    reset = 1'b1; s_valid = 1'b0; s_kind = 1'b0; s_row = '0; s_col = '0;
    s_data = '0; s_last = 1'b0; start = 1'b0;
    for (int k = 0; k < RC; k++) hseq[k] = '1;
    model_clear();
    repeat (3) @(negedge clk);
    chk("reset s_ready", s_ready, 0);
    chk("reset pe_reset", pe_reset, 1);
    chk("reset pe_ena", pe_ena, 0);
    chk("reset done", done, 0);
    chk("reset busy", busy, 0);
    chk("reset best_h", best_h, 24'hFFFFFF);
    chk("reset best_cycle", best_cycle, 0);
    check_regs("reset");
    reset = 1'b0;

    // first problem: J[1][2]=-5, phase[3]=0x40 (last)
    send_beat(0, 1, 2, 32'hFFFF_FFFB, 1'b0);
    send_beat(1, 3, 0, 32'h0000_0040, 1'b1);
    idle();
    chk("loaded J[2][1]", coupling_factor[(2*N+1)*JW +: JW], 32'hFFFF_FFFB);
    chk("loaded phase[3]", coupling_phase[3*PW +: PW], 8'h40);
    chk("loaded s_ready", s_ready, 0);
    chk("loaded busy", busy, 1);
    check_regs("load1");

    // beat presented while not ready must not land
    @(negedge clk);
    s_valid = 1'b1; s_kind = 1'b0; s_row = 3'd0; s_col = 3'd1; s_data = 32'd123; s_last = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("held s_ready", s_ready, 0);
    end
    s_valid = 1'b0;
    check_regs("held");

    // directed stream: early zeros ignored, first of two 1s wins
    fill_random_h(10, 500000);
    hseq[2] = 24'd9; hseq[3] = 24'd3; hseq[4] = 24'd5; hseq[5] = 24'd3;
    hseq[700] = 24'd1; hseq[701] = 24'd1;
    run_anneal();
    chk("directed best_h", best_h, 24'd1);
    chk("directed best_cycle", best_cycle, 10'd700);

    // from DONE: a beat returns to LOAD and clears err; bad indices dropped but consumed
    m_err = 1'b0;
    send_beat(1, 0, 0, 32'h0000_01A5, 1'b0);
    chk("phase upper bits ignored", coupling_phase[0 +: PW], 8'hA5);
    send_beat(0, 4, 4, 32'd7, 1'b0);
    chk("diag err", err, m_err);
    chk("diag s_ready", s_ready, 1);
    send_beat(0, 7, 0, 32'd99, 1'b0);
    chk("bad idx err", err, m_err);
    chk("bad idx s_ready", s_ready, 1);
    @(negedge clk);
    s_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start in LOAD ignored", s_ready, 1);
    random_load(6);
    chk("load2 s_ready", s_ready, 0);
    check_regs("load2");

    fill_random_h(100, 400);
    run_anneal();
    fill_random_h(50, 300);
    run_anneal();

    // reload after DONE: err must clear on re-entry to LOAD
    m_err = 1'b0;
    send_beat(1, 2, 0, $urandom, 1'b0);
    chk("reload err cleared", err, m_err);
    random_load(5);
    check_regs("load3");
    fill_random_h(0, 1000);
    run_anneal();

    // reset in the middle of the anneal window
    fill_random_h(100, 200);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    ena_cnt = 0;
    while (ena_cnt < 301 && w < RC) begin
      @(negedge clk);
      w++;
      if (pe_ena) ena_cnt++;
    end
    chk("abort reached cnt 300", ena_cnt, 301);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    chk("abort pe_ena", pe_ena, 0);
    chk("abort pe_reset", pe_reset, 1);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort best_h", best_h, 24'hFFFFFF);
    check_regs("abort");

    random_load(4);
    fill_random_h(0, 16'hFFFF);
    run_anneal();

    repeat (3) @(negedge clk);
    chk("scoreboard drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global timeout: got running want finished");
    $fatal(1);
  end
endmodule
